pc_fetch_sequencer: RTL
=======================

Name: pc_fetch_sequencer

Overview:
- Sequential consumer of the branch/jump target adder output (PCTarget) and the PCSrc redirect.
- Owns the architectural fetch PC and issues one instruction-memory request at a time over a valid/ready request and valid response handshake.
- Presents each fetched instruction with its PC and PC+4 to decode; honours a decode stall.
- Faults on a misaligned redirect target.

Parameters:
- RESET_VECTOR, 32'h0000_0000, fetch address after reset (must be word aligned).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- PCTarget  in  32  redirect target from branch/jump target adder
- PCSrc  in  1  redirect strobe; 1 = take PCTarget this cycle
- Stall  in  1  decode cannot accept the presented instruction
- ImemReqValid  out  1  request valid
- ImemReqAddr  out  32  request word address
- ImemReqReady  in  1  memory accepts request
- ImemRspValid  in  1  response valid (one per accepted request, ≥1 cycle after accept)
- ImemRspData  in  32  instruction word
- InstrValid  out  1  Instr/PC/PCPlus4 valid
- Instr  out  32  fetched instruction
- PC  out  32  address of Instr
- PCPlus4  out  32  PC + 4, modulo 2^32
- MisalignFault  out  1  sticky; redirect target had [1:0] != 0
- FaultAddr  out  32  offending PCTarget

Behaviour:
- Reset (async assert, sync release):
  - State = REQ; FetchPC = RESET_VECTOR; Kill = 0.
  - InstrValid = 0; Instr, PC, PCPlus4, FaultAddr = 0; MisalignFault = 0.
  - ImemReqValid is 0 while rst_n is low; it is 1 from the first cycle after release.
- Datapath: FetchPC is 32 bit, increments by 4 with wrap 32'hFFFF_FFFC -> 32'h0000_0000. All outputs are registered except ImemReqValid and ImemReqAddr, which decode from state and FetchPC.
- State REQ:
  - ImemReqValid = 1; ImemReqAddr = FetchPC.
  - On ImemReqReady: ReqPC <= FetchPC, FetchPC <= FetchPC + 4, go to WAIT.
- State WAIT:
  - ImemReqValid = 0.
  - On ImemRspValid with Kill = 0: Instr <= ImemRspData, PC <= ReqPC, PCPlus4 <= ReqPC + 4, InstrValid <= 1, go to HOLD.
  - On ImemRspValid with Kill = 1: discard the data, clear Kill, go to REQ.
- State HOLD:
  - InstrValid = 1; outputs are stable while Stall = 1.
  - Cycle with Stall = 0 = consumed: InstrValid <= 0, go to REQ.
  - Minimum issue interval: 3 cycles (REQ, WAIT, HOLD) with zero-wait memory.
- Redirect (PCSrc = 1 and PCTarget[1:0] == 0, any state except FAULT) overrides the normal transitions:
  - FetchPC <= PCTarget (no +4 applied); InstrValid <= 0.
  - REQ with ImemReqReady = 0: stay in REQ; the address changes next cycle.
  - REQ with ImemReqReady = 1: the handshake completes for the old address; go to WAIT with Kill = 1.
  - WAIT with ImemRspValid = 0: set Kill, stay in WAIT.
  - WAIT with ImemRspValid = 1: discard the response, go to REQ.
  - HOLD: drop the instruction regardless of Stall, go to REQ.
  - Redirect while Kill is already set: Kill stays 1; FetchPC takes the latest target.
- Misaligned redirect (PCSrc = 1, PCTarget[1:0] != 0):
  - MisalignFault <= 1, FaultAddr <= PCTarget, InstrValid <= 0, go to FAULT.
  - A pending response is absorbed and ignored.
- State FAULT:
  - ImemReqValid = 0; PCSrc and Stall are ignored.
  - Exit only via rst_n.
- Stall outside HOLD has no effect.
- Reset asserted mid-transaction: all state clears immediately. The memory must drop any in-flight response on reset.

Test Plan:
- Reset release, RESET_VECTOR = 32'h100, memory ready always, 1-cycle response: ImemReqAddr sequence 100, 104, 108; each instruction shown with PC = 100/104/108 and PCPlus4 = 104/108/10C; InstrValid pulses 1 cycle every 3 cycles.
- Stall = 1 for 5 cycles while in HOLD with Instr = 32'h00500093: Instr, PC and InstrValid stay constant for 5 cycles; the next request issues 1 cycle after Stall falls.
- PCSrc = 1 with PCTarget = 32'h200 in HOLD while Stall = 1: InstrValid drops next cycle; the next ImemReqAddr is 200, then 204.
- PCSrc with PCTarget = 32'h300 in WAIT, response arrives 3 cycles later with data 32'hDEADBEEF: that data is never presented; the next request address is 300.
- PCSrc with PCTarget = 32'h402: MisalignFault = 1 and FaultAddr = 402 next cycle; ImemReqValid stays 0 for 20 cycles; rst_n low clears both.
- FetchPC = 32'hFFFF_FFFC: PC = FFFF_FFFC, PCPlus4 = 0000_0000, next ImemReqAddr = 0000_0000.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// +------------------------------------------------------------------+
// | Module      : pc_fetch_sequencer                                 |
// | Description : Fetch PC owner; one-at-a-time imem request/response|
// |               with redirect, decode stall and misalign fault.    |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
`default_nettype none

module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCTarget,
  input  logic        PCSrc,
  input  logic        Stall,
  output logic        ImemReqValid,
  output logic [31:0] ImemReqAddr,
  input  logic        ImemReqReady,
  input  logic        ImemRspValid,
  input  logic [31:0] ImemRspData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        MisalignFault,
  output logic [31:0] FaultAddr
);

  localparam logic [1:0] c_st_req   = 2'd0;
  localparam logic [1:0] c_st_wait  = 2'd1;
  localparam logic [1:0] c_st_hold  = 2'd2;
  localparam logic [1:0] c_st_fault = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_pc;
  logic        r_kill;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_fetch_pc_nxt;
  logic [31:0] w_req_pc_nxt;
  logic        w_kill_nxt;
  logic        w_iv_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pcplus4_nxt;
  logic        w_fault_nxt;
  logic [31:0] w_faddr_nxt;
  logic        w_live;
  logic        w_redirect;
  logic        w_misalign;

  assign w_live     = (r_state != c_st_fault);
  assign w_redirect = w_live && PCSrc && (PCTarget[1:0] == 2'b00);
  assign w_misalign = w_live && PCSrc && (PCTarget[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_st_req;
      r_fetch_pc    <= RESET_VECTOR;
      r_req_pc      <= '0;
      r_kill        <= 1'b0;
      InstrValid    <= 1'b0;
      Instr         <= '0;
      PC            <= '0;
      PCPlus4       <= '0;
      MisalignFault <= 1'b0;
      FaultAddr     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_req_pc      <= w_req_pc_nxt;
      r_kill        <= w_kill_nxt;
      InstrValid    <= w_iv_nxt;
      Instr         <= w_instr_nxt;
      PC            <= w_pc_nxt;
      PCPlus4       <= w_pcplus4_nxt;
      MisalignFault <= w_fault_nxt;
      FaultAddr     <= w_faddr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    w_kill_nxt     = r_kill;
    w_iv_nxt       = InstrValid;
    w_instr_nxt    = Instr;
    w_pc_nxt       = PC;
    w_pcplus4_nxt  = PCPlus4;
    w_fault_nxt    = MisalignFault;
    w_faddr_nxt    = FaultAddr;
    if (w_misalign) begin
      w_fault_nxt = 1'b1;
      w_faddr_nxt = PCTarget;
      w_iv_nxt    = 1'b0;
      w_kill_nxt  = 1'b0;
      w_state_nxt = c_st_fault;
    end else if (w_redirect) begin
      // Target is taken as-is; an in-flight request is marked for discard.
      w_fetch_pc_nxt = PCTarget;
      w_iv_nxt       = 1'b0;
      case (r_state)
        c_st_req: begin
          if (ImemReqReady) begin
            w_req_pc_nxt = r_fetch_pc;
            w_kill_nxt   = 1'b1;
            w_state_nxt  = c_st_wait;
          end
        end
        c_st_wait: begin
          if (ImemRspValid) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = c_st_req;
          end else begin
            w_kill_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = c_st_req;
      endcase
    end else begin
      case (r_state)
        c_st_req: begin
          if (ImemReqReady) begin
            w_req_pc_nxt   = r_fetch_pc;
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            w_state_nxt    = c_st_wait;
          end
        end
        c_st_wait: begin
          if (ImemRspValid) begin
            if (r_kill) begin
              w_kill_nxt  = 1'b0;
              w_state_nxt = c_st_req;
            end else begin
              w_instr_nxt   = ImemRspData;
              w_pc_nxt      = r_req_pc;
              w_pcplus4_nxt = r_req_pc + 32'd4;
              w_iv_nxt      = 1'b1;
              w_state_nxt   = c_st_hold;
            end
          end
        end
        c_st_hold: begin
          if (!Stall) begin
            w_iv_nxt    = 1'b0;
            w_state_nxt = c_st_req;
          end
        end
        default: w_state_nxt = c_st_fault;
      endcase
    end
  end

  // Request is suppressed combinationally while reset is held.
  always_comb begin
    ImemReqValid = rst_n && (r_state == c_st_req);
    ImemReqAddr  = r_fetch_pc;
  end

endmodule

`default_nettype wire
